dct8_stream: RTL and testbench
==============================

Name: dct8_stream

Overview:
- Pipelined, streaming, parametrised 8-point 1-D forward DCT.
- Accepts one signed sample per handshake and, after 8 samples, emits the 8 coefficients y0..y7 one per handshake under backpressure.
- Sits between the block/row scanner and the transpose buffer of the 2-D DCT path.
- Uses signed two's-complement fixed-point arithmetic throughout, with rounding and optional saturation.

Parameters:
- DATA_W, 16, width of input samples and output coefficients (signed integer).
- FRAC_W, 10, fractional bits of the cosine constants and of internal products.
- ACC_W, DATA_W+FRAC_W+5, internal accumulator width; must be at least DATA_W+FRAC_W+4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed sample; the k-th accepted sample of a block is x_k.
- out_valid  out  1  out_data holds a coefficient.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  signed coefficient y_k, emitted in order k=0..7.
- out_idx  out  3  index k of the coefficient currently on out_data.
- out_last  out  1  high together with out_valid when k=7.

Behaviour:
- Reset (async assert, sync release): state=LOAD, sample count=0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, sample registers=0.
- Constants: Ck = round(cos(k*pi/16)/2 * 2^FRAC_W), k=1..7, computed at elaboration. For FRAC_W=10: 502, 473, 426, 362, 284, 196, 100.
- State LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, store sample into x[cnt] and increment cnt.
  - On the 8th accept (cnt=7), go to OUT with k=0 and register y0 into out_data. out_valid rises in the next cycle, giving latency 1 cycle from the 8th accepted sample.
- State OUT:
  - in_ready=0; out_valid=1.
  - On out_valid&&out_ready with k<7, register y_{k+1} and increment k. Back-to-back transfers give 1 coefficient per cycle.
  - On the handshake at k=7, return to LOAD with cnt=0 and out_valid=0 in the next cycle. There is no overlap between LOAD and OUT.
  - out_valid must stay high and out_data/out_idx stable while out_ready=0.
- Butterflies, at DATA_W+1 bits:
  - s_i = x_i + x_{7-i}; d_i = x_i - x_{7-i}.
  - y0 = C4*(s0+s1+s2+s3); y4 = C4*(s0-s1-s2+s3).
  - y2 = C2*(s0-s3) + C6*(s1-s2); y6 = C6*(s0-s3) - C2*(s1-s2).
  - y1 = C1*d0 + C3*d1 + C5*d2 + C7*d3; y3 = C3*d0 - C7*d1 - C1*d2 - C5*d3.
  - y5 = C5*d0 - C1*d1 + C7*d2 + C3*d3; y7 = C7*d0 - C5*d1 + C3*d2 - C1*d3.
- Sums of products are formed at ACC_W bits with no intermediate truncation.
- Result = (acc + 2^(FRAC_W-1)) >>> FRAC_W, i.e. round half toward +inf, then narrowed to DATA_W.
- in_valid while in_ready=0 is ignored; the sample is not consumed.
- Reset asserted mid-block discards partial samples and any pending coefficients.

Optional Feature:
- Macro DCT8_STREAM_SAT_EN.
- Defined: the narrowed result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Adds output port sat_flag (out, 1), high with out_valid when the current coefficient was clipped; reset value 0.
- Undefined: the result is wrapped, taking the low DATA_W bits; there is no sat_flag port.

Test Plan:
- DC block: x0..x7=100, out_ready=1 -> y0=283, y1..y7=0; out_valid first high 1 cycle after the 8th accept; out_last with y7.
- Impulse: x0=1000, others 0 -> y0..y7 = 354, 490, 462, 416, 354, 277, 191, 98.
- Saturation: all x=32767. With DCT8_STREAM_SAT_EN: y0=32767 and sat_flag=1. Without the macro: y0=27133 (wrap of 92669).
- Backpressure: impulse block with out_ready toggling 1,0,0,1 each cycle -> out_data/out_idx held while stalled; exactly 8 transfers; in_ready=0 until the cycle after the y7 handshake.
- Input gaps and ignore: in_valid held high during OUT -> no sample consumed; the next block of samples alternating +50/-50 produces y0=0 and y7 = round(C-weighted sum), checked against the bench reference model.
- Reset mid-operation: assert rst after 5 samples, and again at k=3 in OUT -> all outputs return to reset values; the next full block produces correct results.

Source files
------------

// File: rtl/dct8_stream.sv
// dct8_stream: streaming 8-point 1-D forward DCT (fixed point, rounded, optionally saturated).
// Latency: y0 is registered on the 8th accepted sample (valid 1 cycle later); then 1 coeff/cycle.
// Backpressure: LOAD and OUT phases never overlap; out_* held stable while out_ready=0.
//
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data sample input;
//        out_valid/out_ready/out_data/out_idx/out_last coefficient output;
//        sat_flag only when DCT8_STREAM_SAT_EN is defined (saturating narrowing),
//        otherwise the narrowed result wraps to DATA_W bits.
module dct8_stream #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int ACC_W  = DATA_W + FRAC_W + 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_last
`ifdef DCT8_STREAM_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  // cos(k*pi/16) * 2^30 table, scaled at elaboration to round(cos/2 * 2^FRAC_W).
  function automatic int ck(input int kk);
    longint t;
    case (kk)
      1:       t = 64'sd1053110176;
      2:       t = 64'sd992008095;
      3:       t = 64'sd892783698;
      4:       t = 64'sd759250125;
      5:       t = 64'sd596538995;
      6:       t = 64'sd410903207;
      7:       t = 64'sd209476638;
      default: t = 64'sd0;
    endcase
    return int'((t + (longint'(1) <<< (30 - FRAC_W))) >>> (31 - FRAC_W));
  endfunction

  localparam logic signed [ACC_W-1:0] K1  = ACC_W'(ck(1));
  localparam logic signed [ACC_W-1:0] K2  = ACC_W'(ck(2));
  localparam logic signed [ACC_W-1:0] K3  = ACC_W'(ck(3));
  localparam logic signed [ACC_W-1:0] K4  = ACC_W'(ck(4));
  localparam logic signed [ACC_W-1:0] K5  = ACC_W'(ck(5));
  localparam logic signed [ACC_W-1:0] K6  = ACC_W'(ck(6));
  localparam logic signed [ACC_W-1:0] K7  = ACC_W'(ck(7));
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(longint'(1) <<< (FRAC_W - 1));

  typedef enum logic {S_LOAD, S_OUT} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] k;
  logic signed [DATA_W-1:0] x  [8];
  logic signed [DATA_W-1:0] xv [8];
  logic signed [ACC_W-1:0]  s  [4];
  logic signed [ACC_W-1:0]  d  [4];
  logic signed [ACC_W-1:0]  acc [8];
  logic signed [ACC_W-1:0]  rnd;
  logic [2:0]               sel;
  logic [DATA_W-1:0]        y_sel;
  logic                     clip_sel;
  logic                     clip_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 3'd7) state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready && k == 3'd7) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // y0 is computed in the same cycle x7 arrives, so the live input stands in for x[7].
  always_comb begin
    for (int i = 0; i < 8; i++) xv[i] = x[i];
    if (state == S_LOAD) xv[7] = $signed(in_data);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s[i] = ACC_W'(xv[i]) + ACC_W'(xv[7-i]);
      d[i] = ACC_W'(xv[i]) - ACC_W'(xv[7-i]);
    end
    acc[0] = K4 * (s[0] + s[1] + s[2] + s[3]);
    acc[4] = K4 * (s[0] - s[1] - s[2] + s[3]);
    acc[2] = K2 * (s[0] - s[3]) + K6 * (s[1] - s[2]);
    acc[6] = K6 * (s[0] - s[3]) - K2 * (s[1] - s[2]);
    acc[1] = K1 * d[0] + K3 * d[1] + K5 * d[2] + K7 * d[3];
    acc[3] = K3 * d[0] - K7 * d[1] - K1 * d[2] - K5 * d[3];
    acc[5] = K5 * d[0] - K1 * d[1] + K7 * d[2] + K3 * d[3];
    acc[7] = K7 * d[0] - K5 * d[1] + K3 * d[2] - K1 * d[3];
  end

  // Coefficient to be registered next: y0 at the end of LOAD, y_{k+1} during OUT.
  assign sel = (state == S_LOAD) ? 3'd0 : k + 3'd1;
  assign rnd = (acc[sel] + RND) >>> FRAC_W;

`ifdef DCT8_STREAM_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  always_comb begin
    y_sel    = rnd[DATA_W-1:0];
    clip_sel = 1'b0;
    if (rnd > MAXV) begin
      y_sel    = MAXV[DATA_W-1:0];
      clip_sel = 1'b1;
    end else if (rnd < MINV) begin
      y_sel    = MINV[DATA_W-1:0];
      clip_sel = 1'b1;
    end
  end
  assign sat_flag = clip_q & out_valid;
`else
  logic unused_hi;
  assign y_sel     = rnd[DATA_W-1:0];
  assign clip_sel  = 1'b0;
  assign unused_hi = ^{rnd[ACC_W-1:DATA_W], clip_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      k        <= '0;
      out_data <= '0;
      clip_q   <= 1'b0;
      for (int i = 0; i < 8; i++) x[i] <= '0;
    end else if (state == S_LOAD) begin
      if (in_valid) begin
        x[cnt] <= $signed(in_data);
        cnt    <= cnt + 3'd1;   // wraps to 0 after the 8th sample
        if (cnt == 3'd7) begin
          out_data <= y_sel;
          clip_q   <= clip_sel;
          k        <= '0;
        end
      end
    end else if (out_ready) begin
      if (k != 3'd7) begin
        out_data <= y_sel;
        clip_q   <= clip_sel;
        k        <= k + 3'd1;
      end else begin
        k <= '0;
      end
    end
  end

  assign out_idx  = k;
  assign out_last = out_valid && (k == 3'd7);

endmodule

// File: tb/tb_dct8_stream.sv
// tb_dct8_stream: randomized self-checking bench for dct8_stream against a
// matrix-form DCT reference (cosine index folding, plain integer arithmetic).
// Default parameters (DATA_W=16, FRAC_W=10); honours DCT8_STREAM_SAT_EN.
module tb_dct8_stream;

  typedef logic signed [15:0] blk_t [8];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
`ifdef DCT8_STREAM_SAT_EN
  logic        sat_flag;
`endif

  int passed = 0;
  int total  = 0;
  int ctab [9] = '{0, 502, 473, 426, 362, 284, 196, 100, 0};

  always #5 clk = ~clk;

  dct8_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef DCT8_STREAM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  // y_k = sum_n c(k,n) x_n with c(k,n) = cos((2n+1)k*pi/16) in the scaled table,
  // y0 using the C4 weight for every sample.
  function automatic logic [15:0] ref_y(input int k, input blk_t xs, output bit clipped);
    longint acc, r;
    int m, c;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      if (k == 0) c = ctab[4];
      else begin
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        if (m > 8) c = -ctab[16 - m];
        else       c = ctab[m];
      end
      acc += longint'(c) * longint'(xs[n]);
    end
    r = (acc + 512) >>> 10;
    clipped = 1'b0;
`ifdef DCT8_STREAM_SAT_EN
    if (r > 32767)  begin r = 32767;  clipped = 1'b1; end
    if (r < -32768) begin r = -32768; clipped = 1'b1; end
`endif
    return 16'(r);
  endfunction

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({in_ready, out_valid, out_data, out_idx, out_last} !== {1'b1, 1'b0, 16'd0, 3'd0, 1'b0})
      $display("FAIL %s: rdy=%b vld=%b dat=%0d idx=%0d last=%b, want rdy=1 vld=0 dat=0 idx=0 last=0",
               tag, in_ready, out_valid, out_data, out_idx, out_last);
    else passed++;
`ifdef DCT8_STREAM_SAT_EN
    total++;
    if (sat_flag !== 1'b0) $display("FAIL %s_sat: got %b want 0", tag, sat_flag);
    else passed++;
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_block(input blk_t xs, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = xs[i];
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL load_ready[%0d]: rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
      else passed++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL latency: out_valid=%b want 1 one cycle after 8th accept", out_valid);
    else passed++;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  // stop_at < 8 returns while coefficient stop_at is presented (no handshake).
  task automatic collect(input blk_t xs, input int mode, input int stop_at, input bit junk);
    int n, cyc;
    bit pstall, clip;
    logic [15:0] pd, e;
    logic [2:0] pi;
    int pat [4] = '{1, 0, 0, 1};
    n = 0; cyc = 0; pstall = 1'b0; pd = '0; pi = '0;
    while (n < 8 && cyc < 100) begin
      if (n == stop_at) begin
        in_valid = 1'b0;
        return;
      end
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] != 0 : $urandom % 2 == 1;
      in_valid  = junk;
      in_data   = 16'($urandom);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL out_phase[%0d]: vld=%b rdy=%b want vld=1 rdy=0", n, out_valid, in_ready);
      else passed++;
      if (pstall) begin
        total++;
        if (out_data !== pd || out_idx !== pi)
          $display("FAIL hold: dat=%0d idx=%0d want dat=%0d idx=%0d", out_data, out_idx, pd, pi);
        else passed++;
      end
      if (out_ready) begin
        e = ref_y(n, xs, clip);
        total++;
        if (out_data !== e || out_idx !== 3'(n) || out_last !== (n == 7))
          $display("FAIL coef[%0d]: dat=%0d idx=%0d last=%b want dat=%0d idx=%0d last=%b",
                   n, $signed(out_data), out_idx, out_last, $signed(e), n, n == 7);
        else passed++;
`ifdef DCT8_STREAM_SAT_EN
        total++;
        if (sat_flag !== clip) $display("FAIL sat_flag[%0d]: got %b want %b", n, sat_flag, clip);
        else passed++;
`endif
        n++;
      end
      pstall = !out_ready;
      pd = out_data;
      pi = out_idx;
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 100) begin
      total++;
      $display("FAIL collect_timeout: got %0d transfers want 8", n);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL release: rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  task automatic test_dc();
    blk_t xs;
    for (int i = 0; i < 8; i++) xs[i] = 16'sd100;
    load_block(xs, 1'b0);
    total++;
    if (out_data !== 16'd283) $display("FAIL dc_y0: got %0d want 283", out_data);
    else passed++;
    collect(xs, 0, 8, 1'b0);
  endtask

  task automatic test_impulse(input int mode);
    blk_t xs;
    for (int i = 0; i < 8; i++) xs[i] = 16'sd0;
    xs[0] = 16'sd1000;
    load_block(xs, 1'b0);
    total++;
    if (out_data !== 16'd354) $display("FAIL impulse_y0: got %0d want 354", out_data);
    else passed++;
    collect(xs, mode, 8, 1'b0);
  endtask

  task automatic test_saturation();
    blk_t xs;
    for (int i = 0; i < 8; i++) xs[i] = 16'sd32767;
    load_block(xs, 1'b0);
    total++;
`ifdef DCT8_STREAM_SAT_EN
    if (out_data !== 16'd32767 || sat_flag !== 1'b1)
      $display("FAIL sat_y0: dat=%0d flag=%b want 32767 flag=1", out_data, sat_flag);
    else passed++;
`else
    if (out_data !== 16'd27133) $display("FAIL wrap_y0: got %0d want 27133", out_data);
    else passed++;
`endif
    collect(xs, 0, 8, 1'b0);
  endtask

  task automatic test_ignore();
    blk_t xs, alt;
    for (int i = 0; i < 8; i++) begin
      xs[i]  = 16'($urandom_range(0, 2000)) - 16'sd1000;
      alt[i] = (i % 2 == 0) ? 16'sd50 : -16'sd50;
    end
    load_block(xs, 1'b0);
    collect(xs, 2, 8, 1'b1);
    load_block(alt, 1'b0);
    total++;
    if (out_data !== 16'd0) $display("FAIL alt_y0: got %0d want 0", out_data);
    else passed++;
    collect(alt, 0, 8, 1'b0);
  endtask

  task automatic test_reset_mid();
    blk_t xs;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(negedge clk);
    end
    do_reset("reset_mid_load");
    test_impulse(0);
    for (int i = 0; i < 8; i++) xs[i] = 16'($urandom);
    load_block(xs, 1'b0);
    collect(xs, 0, 3, 1'b0);
    total++;
    if (out_idx !== 3'd3) $display("FAIL mid_out_idx: got %0d want 3", out_idx);
    else passed++;
    do_reset("reset_mid_out");
    test_impulse(0);
  endtask

  task automatic test_random();
    blk_t xs;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++) xs[i] = 16'($urandom);
      load_block(xs, 1'b1);
      collect(xs, 2, 8, b % 2 == 1);
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_impulse(0);
    test_saturation();
    test_impulse(1);
    test_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
